// File: rtl/mem_bus_arbiter.sv
// Fetch / load-store arbiter in front of a single-port memory.
// One transaction outstanding, alternating priority on contention, and a wait counter that forces completion.
module mem_bus_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [XLEN/8-1:0] mem_wstrb,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [XLEN-1:0]   mem_rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN/8-1:0] bus_wstrb,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_spurious
);
    // state | meaning
    // IDLE  | nothing outstanding; arbitrate and grant
    // REQ   | bus_req high, waiting for bus_ready
    // RESP  | request accepted, waiting for bus_rvalid
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_win_q, last_win_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              bus_we_q, bus_we_d;
    logic [XLEN/8-1:0] bus_wstrb_q, bus_wstrb_d;
    logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_spurious_q, err_spurious_d;

    logic              grant;
    logic              win_mem;
    logic              expire;
    logic              done;
    logic [XLEN-1:0]   done_data;

    assign expire = (cnt_q == CNT_LAST);

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_win_d     = last_win_q;
        cnt_d          = (state_q == ST_IDLE) ? '0 : cnt_q + 1'b1;
        bus_we_d       = bus_we_q;
        bus_wstrb_d    = bus_wstrb_q;
        bus_addr_d     = bus_addr_q;
        bus_wdata_d    = bus_wdata_q;
        err_timeout_d  = err_timeout_q;
        err_spurious_d = err_spurious_q | (bus_rvalid && (state_q != ST_RESP));
        grant          = 1'b0;
        win_mem        = 1'b0;
        done           = 1'b0;
        done_data      = '0;
        case (state_q)
            ST_IDLE: begin
                if (if_req || mem_req) begin
                    grant   = 1'b1;
                    // On contention the requester that did not win last time goes first
                    win_mem = mem_req && (!if_req || (last_win_q == OWN_IF));
                    owner_d = win_mem ? OWN_MEM : OWN_IF;
                    if (if_req && mem_req) begin
                        last_win_d = owner_d;
                    end
                    if (win_mem) begin
                        bus_we_d    = mem_we;
                        bus_wstrb_d = mem_wstrb;
                        bus_addr_d  = mem_addr;
                        bus_wdata_d = mem_wdata;
                    end else begin
                        bus_we_d    = 1'b0;
                        bus_wstrb_d = '0;
                        bus_addr_d  = if_addr;
                        bus_wdata_d = '0;
                    end
                    state_d = ST_REQ;
                    cnt_d   = '0;
                end
            end
            ST_REQ: begin
                if (bus_ready) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else if (expire) begin
                    done          = 1'b1;
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (bus_rvalid) begin
                    done      = 1'b1;
                    done_data = bus_we_q ? '0 : bus_rdata;
                    state_d   = ST_IDLE;
                end else if (expire) begin
                    done          = 1'b1;
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            owner_q        <= OWN_IF;
            last_win_q     <= OWN_IF;
            cnt_q          <= '0;
            bus_we_q       <= 1'b0;
            bus_wstrb_q    <= '0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_win_q     <= last_win_d;
            cnt_q          <= cnt_d;
            bus_we_q       <= bus_we_d;
            bus_wstrb_q    <= bus_wstrb_d;
            bus_addr_q     <= bus_addr_d;
            bus_wdata_q    <= bus_wdata_d;
            err_timeout_q  <= err_timeout_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    // Grants are combinational from the requests, so hold them off while reset is asserted
    assign if_gnt       = rst_n && grant && !win_mem;
    assign mem_gnt      = rst_n && grant && win_mem;
    assign if_rvalid    = done && (owner_q == OWN_IF);
    assign mem_rvalid   = done && (owner_q == OWN_MEM);
    assign if_rdata     = if_rvalid ? done_data : '0;
    assign mem_rdata    = mem_rvalid ? done_data : '0;
    assign bus_req      = (state_q == ST_REQ);
    assign bus_we       = bus_we_q;
    assign bus_wstrb    = bus_wstrb_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign busy         = (state_q != ST_IDLE);
    assign err_timeout  = err_timeout_q;
    assign err_spurious = err_spurious_q;

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data and address width.
REQ-002 Parameter TIMEOUT, default 255, max cycles spent in REQ or RESP before forced completion; range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 if_req  input  1  fetch read request; held with if_addr stable until if_gnt.
REQ-006 if_addr  input  XLEN  fetch address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch response valid, one-cycle pulse.
REQ-009 if_rdata  output  XLEN  fetch response data.
REQ-010 mem_req  input  1  load/store request; held with its fields stable until mem_gnt.
REQ-011 mem_we  input  1  1 = store, 0 = load.
REQ-012 mem_wstrb  input  XLEN/8  store byte enables.
REQ-013 mem_addr, mem_wdata  input  XLEN each  load/store address, store data.
REQ-014 mem_gnt  output  1  load/store request accepted this cycle.
REQ-015 mem_rvalid  output  1  load data or store ack, one-cycle pulse.
REQ-016 mem_rdata  output  XLEN  load data (0 for stores).
REQ-017 bus_req  output  1  request to the single-port memory.
REQ-018 bus_we, bus_wstrb, bus_addr, bus_wdata  output  1/XLEN/8/XLEN/XLEN  registered copy of the granted request.
REQ-019 bus_ready  input  1  memory accepts bus_req this cycle.
REQ-020 bus_rvalid  input  1  memory response (read data or write ack).
REQ-021 bus_rdata  input  XLEN  memory read data.
REQ-022 busy  output  1  high when state is not IDLE.
REQ-023 err_timeout  output  1  sticky, set on any timeout.
REQ-024 err_spurious  output  1  sticky, set when bus_rvalid=1 outside RESP.

Function
REQ-025 FSM states IDLE, REQ, RESP; one transaction outstanding; owner register (IF or MEM) plus last_win register.
REQ-026 IDLE: only if_req -> grant IF; only mem_req -> grant MEM; both -> grant requester that is not last_win; neither -> stay IDLE.
REQ-027 Grant: that cycle pulse the winner's gnt (combinational), latch its fields into the bus_* registers (IF: we=0, wstrb=0, wdata=0), set owner, set last_win only when both requested, go to REQ.
REQ-028 gnt outputs are 0 in every state except IDLE; never both high.
REQ-029 REQ: bus_req=1; bus_ready=1 -> RESP next cycle; otherwise stay, fields unchanged.
REQ-030 RESP: bus_req=0; bus_rvalid=1 -> owner's rvalid=1 same cycle, owner's rdata=bus_rdata for loads/fetches, 0 for stores, next state IDLE.
REQ-031 Non-owner rvalid is 0 and non-owner rdata is 0 at all times; rdata outputs are 0 whenever their rvalid is 0.
REQ-032 Minimum transaction: grant at cycle 0, bus_req at cycle 1, owner rvalid at cycle 2 (bus_ready and bus_rvalid both immediate), next grant possible at cycle 3.
REQ-033 Wait counter, width clog2(TIMEOUT+1): cleared on entry to REQ and RESP, increments each cycle spent in either state.
REQ-034 Counter reaching TIMEOUT in REQ or RESP: owner rvalid pulses with rdata=0, err_timeout set, bus_req dropped, next state IDLE; a real completion in the same cycle takes precedence, with no error.
REQ-035 bus_rvalid in IDLE or REQ is ignored for responses and sets err_spurious.
REQ-036 Error flags clear only on reset.

Reset
REQ-037 rst_n low, asynchronously: state IDLE, owner IF, last_win IF, counter 0, bus_* registers 0, err flags 0; all outputs 0.
REQ-038 Reset mid-transaction abandons it: no rvalid pulse is generated, and the first grant after release follows REQ-026.

Verification
REQ-039 Only if_req=1 at addr 0x100; bus_ready and bus_rvalid immediate, rdata 0xDEADBEEF -> if_gnt at cycle 0, bus_addr=0x100 at cycle 1, if_rvalid with 0xDEADBEEF at cycle 2.
REQ-040 if_req and mem_req both held high for 4 transactions after reset -> grant order MEM, IF, MEM, IF.
REQ-041 Store wstrb=4'b0011 to 0x20, bus_ready delayed 3 cycles -> bus_req high 4 cycles with fields stable, mem_rvalid with mem_rdata=0.
REQ-042 TIMEOUT=4, bus_rvalid never asserted -> forced owner rvalid with rdata=0 after 4 RESP cycles, err_timeout=1, then IDLE.
REQ-043 bus_rvalid pulsed in IDLE -> err_spurious=1, no rvalid output.
REQ-044 rst_n low during RESP -> outputs 0 immediately, no rvalid pulse, next contention grants MEM.
